// File: rtl/apb_ram_if.sv
// APB bus bundle between the CPU-side requester and the apb_ram responder.
//   APB_paddr    requester -> responder  byte address
//   APB_pdata    requester -> responder  write data, byte 0 in lane 0
//   APB_psel     requester -> responder  select
//   APB_penable  requester -> responder  access phase
//   APB_pwrite   requester -> responder  1 = write, 0 = read
//   APB_pstb     requester -> responder  write byte strobes, relative to the addressed byte
//   APB_prdata   responder -> requester  read data, lane-0 justified
//   APB_pready   responder -> requester  transfer completes this cycle
//   APB_perr     responder -> requester  error response, valid with APB_pready
interface apb_ram_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   APB_paddr;
    logic [DATA_WIDTH-1:0]   APB_pdata;
    logic [DATA_WIDTH-1:0]   APB_prdata;
    logic                    APB_psel;
    logic                    APB_penable;
    logic                    APB_pwrite;
    logic [DATA_WIDTH/8-1:0] APB_pstb;
    logic                    APB_pready;
    logic                    APB_perr;

    modport master (
        output APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
        input  APB_prdata, APB_pready, APB_perr
    );

    modport slave (
        input  APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
        output APB_prdata, APB_pready, APB_perr
    );
endinterface

// File: rtl/apb_ram.sv
// APB responder with a word-organised RAM (data/program memory on the system bus).
// Registers the setup-phase request, waits WAIT_STATES extra access cycles, then
// completes with APB_pready. Byte-lane writes and lane-0-justified reads follow the
// CPU sub-word convention; out-of-range and word-crossing writes complete with APB_perr.
//   clk   in   single rising-edge clock
//   rts   in   synchronous active-high reset (FSM and outputs only, not the RAM)
//   bus   slave modport of apb_ram_if (APB_* request in, APB_prdata/pready/perr out)
//
// state  | meaning
// IDLE   | waiting for a setup phase (psel & !penable)
// ACCESS | request latched; counting wait states, then presenting pready for one cycle
module apb_ram #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter string                 INIT_FILE   = ""
) (
    input  logic      clk,
    input  logic      rts,
    apb_ram_if.slave  bus
);
    localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0]            WS      = 4'(WAIT_STATES);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [3:0]              stb_q;
    logic                    pready_q;
    logic                    perr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // With zero wait states the response is registered at the setup edge, so the
    // decode must look at the live bus in IDLE and at the latched request otherwise.
    logic [ADDR_WIDTH-1:0]   dec_addr_d;
    logic                    dec_write_d;
    logic [DATA_WIDTH-1:0]   dec_data_d;
    logic [3:0]              dec_stb_d;

    always_comb begin
        dec_addr_d  = addr_q;
        dec_write_d = write_q;
        dec_data_d  = data_q;
        dec_stb_d   = stb_q;
        if (state_q == ST_IDLE) begin
            dec_addr_d  = bus.APB_paddr;
            dec_write_d = bus.APB_pwrite;
            dec_data_d  = bus.APB_pdata;
            dec_stb_d   = bus.APB_pstb;
        end
    end

    logic [ADDR_WIDTH-1:0]   off_d;
    logic [ADDR_WIDTH-1:0]   widx_d;
    logic [1:0]              boff_d;
    logic [7:0]              lane_mask_d;
    logic                    err_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic [DATA_WIDTH-1:0]   wdata_sh_d;
    logic                    we_d;

    assign off_d       = dec_addr_d - BASE_ADDR;
    assign widx_d      = {2'b00, off_d[ADDR_WIDTH-1:2]};
    assign boff_d      = off_d[1:0];
    // Strobes shifted into word lanes; anything landing in bits 7:4 crosses the word.
    assign lane_mask_d = {4'b0000, dec_stb_d} << boff_d;
    assign err_d       = (dec_addr_d < BASE_ADDR) | (widx_d >= DEPTH_A)
                       | (dec_write_d & (|lane_mask_d[7:4]));
    assign rdata_d     = err_d ? '0 : (mem[widx_d[IDX_W-1:0]] >> {boff_d, 3'b000});
    assign wdata_sh_d  = dec_data_d << {boff_d, 3'b000};
    assign we_d        = (state_q == ST_ACCESS) & bus.APB_psel & bus.APB_penable & pready_q
                       & dec_write_d & ~err_d & ~rts;

    always_ff @(posedge clk) begin
        if (we_d) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_mask_d[l]) begin
                    mem[widx_d[IDX_W-1:0]][8*l +: 8] <= wdata_sh_d[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            pready_q <= 1'b0;
            perr_q   <= 1'b0;
            prdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.APB_psel && !bus.APB_penable) begin
                        addr_q  <= bus.APB_paddr;
                        write_q <= bus.APB_pwrite;
                        data_q  <= bus.APB_pdata;
                        stb_q   <= bus.APB_pstb;
                        cnt_q   <= WS;
                        state_q <= ST_ACCESS;
                        if (WS == 4'd0) begin
                            pready_q <= 1'b1;
                            perr_q   <= err_d;
                            prdata_q <= rdata_d;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!bus.APB_psel) begin
                        state_q  <= ST_IDLE;
                        cnt_q    <= 4'd0;
                        pready_q <= 1'b0;
                        perr_q   <= 1'b0;
                        prdata_q <= '0;
                    end else if (bus.APB_penable) begin
                        if (pready_q) begin
                            state_q  <= ST_IDLE;
                            pready_q <= 1'b0;
                            perr_q   <= 1'b0;
                            prdata_q <= '0;
                        end else if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
                            if (cnt_q == 4'd1) begin
                                pready_q <= 1'b1;
                                perr_q   <= err_d;
                                prdata_q <= rdata_d;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.APB_pready = pready_q;
    assign bus.APB_perr   = perr_q;
    assign bus.APB_prdata = prdata_q;
endmodule

// File: tb/tb_apb_ram.sv
// Bench for apb_ram: two instances (no wait states at base 0, three wait states at
// base 0x100), driven with directed transfers. A byte-addressed memory model predicts
// the response; a negedge process compares every cycle; literal values pin the model.
module tb_apb_ram;
    localparam int DEPTH = 64;

    logic clk;
    logic rts;

    apb_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    apb_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0),
              .WAIT_STATES(0), .INIT_FILE("")) dut0 (.clk(clk), .rts(rts), .bus(bus0));
    apb_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(32'h100),
              .WAIT_STATES(3), .INIT_FILE("")) dut1 (.clk(clk), .rts(rts), .bus(bus1));

    logic [31:0] addr_v [2];
    logic [31:0] data_v [2];
    logic [3:0]  stb_v  [2];
    logic        wr_v   [2];
    logic        psel_v [2];
    logic        pen_v  [2];

    assign bus0.APB_paddr   = addr_v[0];
    assign bus0.APB_pdata   = data_v[0];
    assign bus0.APB_pstb    = stb_v[0];
    assign bus0.APB_pwrite  = wr_v[0];
    assign bus0.APB_psel    = psel_v[0];
    assign bus0.APB_penable = pen_v[0];
    assign bus1.APB_paddr   = addr_v[1];
    assign bus1.APB_pdata   = data_v[1];
    assign bus1.APB_pstb    = stb_v[1];
    assign bus1.APB_pwrite  = wr_v[1];
    assign bus1.APB_psel    = psel_v[1];
    assign bus1.APB_penable = pen_v[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle, per instance.
    logic        exp_rdy [2];
    logic        exp_err [2];
    logic [31:0] exp_rd  [2];
    logic        exp_rdc [2];

    logic [7:0]  mb [2][4*DEPTH];

    logic [31:0] g_rd, m_rd;
    logic        g_err, g_rdy, m_err;

    task automatic exp0(input int d);
        exp_rdy[d] = 1'b0;
        exp_err[d] = 1'b0;
        exp_rd[d]  = 32'h0;
        exp_rdc[d] = 1'b1;
    endtask

    task automatic cmp(input int d, input logic rdy, input logic err, input logic [31:0] rd);
        n_checks++;
        if (rdy !== exp_rdy[d]) begin
            n_errors++;
            $display("FAIL dut%0d pready @%0t: got %b expected %b", d, $time, rdy, exp_rdy[d]);
        end
        n_checks++;
        if (err !== exp_err[d]) begin
            n_errors++;
            $display("FAIL dut%0d perr @%0t: got %b expected %b", d, $time, err, exp_err[d]);
        end
        if (exp_rdc[d]) begin
            n_checks++;
            if (rd !== exp_rd[d]) begin
                n_errors++;
                $display("FAIL dut%0d prdata @%0t: got %h expected %h", d, $time, rd, exp_rd[d]);
            end
        end
    endtask

    always @(negedge clk) begin
        cmp(0, bus0.APB_pready, bus0.APB_perr, bus0.APB_prdata);
        cmp(1, bus1.APB_pready, bus1.APB_perr, bus1.APB_prdata);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Byte-addressed view: the addressed byte and the following bytes of its word
    // come back starting at lane 0; writes may not run past the end of the word.
    task automatic model_calc(input int d, input logic [31:0] a, input logic w, input logic [3:0] s);
        longint base, off;
        int boff;
        base  = (d == 0) ? 64'h0 : 64'h100;
        m_err = 1'b0;
        m_rd  = 32'h0;
        if (longint'(a) < base) begin
            m_err = 1'b1;
        end else begin
            off = longint'(a) - base;
            if (off >= 4 * DEPTH) begin
                m_err = 1'b1;
            end else begin
                boff = int'(off % 4);
                if (w) begin
                    for (int i = 0; i < 4; i++) if (s[i] && (boff + i > 3)) m_err = 1'b1;
                end
                if (!m_err) begin
                    for (int j = 0; j < 4 - boff; j++) m_rd = m_rd | (32'(mb[d][int'(off) + j]) << (8 * j));
                end
            end
        end
    endtask

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        int off;
        off = int'(a) - ((d == 0) ? 0 : 32'h100);
        for (int i = 0; i < 4; i++) if (s[i]) mb[d][off + i] = wd[8*i +: 8];
    endtask

    // One transfer; abort_at / rst_at name the access cycle in which psel drops or rts rises.
    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] s, input int abort_at, input int rst_at);
        int  ws;
        bit  stop;
        ws   = (d == 0) ? 0 : 3;
        stop = 0;
        model_calc(d, a, w, s);
        g_rd  = 32'h0;
        g_err = 1'b0;
        g_rdy = 1'b0;
        addr_v[d] = a; wr_v[d] = w; data_v[d] = wd; stb_v[d] = s;
        psel_v[d] = 1'b1; pen_v[d] = 1'b0;
        exp0(d);
        @(posedge clk); #1;
        for (int n = 1; n <= ws + 1 && !stop; n++) begin
            if (n == abort_at) begin
                psel_v[d] = 1'b0;
                pen_v[d]  = 1'b0;
                stop      = 1;
            end else begin
                pen_v[d] = 1'b1;
                if (n == ws + 1) begin
                    exp_rdy[d] = 1'b1;
                    exp_err[d] = m_err;
                    exp_rd[d]  = m_rd;
                    exp_rdc[d] = m_err | ~w;
                end
                if (n == rst_at) begin
                    rts  = 1'b1;
                    stop = 1;
                end
            end
            @(negedge clk);
            if (n == ws + 1 && n != abort_at) begin
                g_rdy = (d == 0) ? bus0.APB_pready : bus1.APB_pready;
                g_err = (d == 0) ? bus0.APB_perr   : bus1.APB_perr;
                g_rd  = (d == 0) ? bus0.APB_prdata : bus1.APB_prdata;
            end
            @(posedge clk); #1;
            rts = 1'b0;
            exp0(d);
        end
        psel_v[d] = 1'b0;
        pen_v[d]  = 1'b0;
        exp0(d);
        if (abort_at < 0 && rst_at < 0 && w && !m_err) model_write(d, a, wd, s);
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        xfer(d, a, 1'b1, wd, s, -1, -1);
    endtask

    task automatic rd(input int d, input logic [31:0] a);
        xfer(d, a, 1'b0, 32'h0, 4'h0, -1, -1);
    endtask

    task automatic expect_ok(input string nm);
        check({nm, " pready"}, 32'(g_rdy), 32'h1);
        check({nm, " perr"}, 32'(g_err), 32'h0);
    endtask

    task automatic expect_rd(input string nm, input logic [31:0] lit);
        expect_ok(nm);
        check({nm, " prdata"}, g_rd, lit);
        check({nm, " model"}, m_rd, lit);
    endtask

    task automatic expect_err(input string nm);
        check({nm, " pready"}, 32'(g_rdy), 32'h1);
        check({nm, " perr"}, 32'(g_err), 32'h1);
        check({nm, " prdata"}, g_rd, 32'h0);
        check({nm, " model err"}, 32'(m_err), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rts = 1'b1;
        for (int d = 0; d < 2; d++) begin
            addr_v[d] = 32'h0; data_v[d] = 32'h0; stb_v[d] = 4'h0;
            wr_v[d] = 1'b0; psel_v[d] = 1'b0; pen_v[d] = 1'b0;
            exp0(d);
            for (int i = 0; i < 4 * DEPTH; i++) mb[d][i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rts = 1'b0;
        check("reset pready0", 32'(bus0.APB_pready), 32'h0);
        check("reset perr0", 32'(bus0.APB_perr), 32'h0);
        check("reset prdata0", bus0.APB_prdata, 32'h0);
        check("reset pready1", 32'(bus1.APB_pready), 32'h0);
        check("reset prdata1", bus1.APB_prdata, 32'h0);

        // Full word write/read, no wait states.
        wr(0, 32'h10, 32'hDEADBEEF, 4'hF);       expect_ok("wr_word");
        rd(0, 32'h10);                            expect_rd("rd_word", 32'hDEADBEEF);

        // Sub-word writes.
        wr(0, 32'h10, 32'h11223344, 4'hF);
        wr(0, 32'h13, 32'h000000AA, 4'h1);       expect_ok("wr_byte3");
        rd(0, 32'h10);                            expect_rd("rd_after_byte", 32'hAA223344);
        wr(0, 32'h10, 32'h11223344, 4'hF);
        wr(0, 32'h12, 32'h0000BEEF, 4'h3);       expect_ok("wr_half2");
        rd(0, 32'h10);                            expect_rd("rd_after_half", 32'hBEEF3344);
        wr(0, 32'h13, 32'h0000CAFE, 4'h3);       expect_err("wr_half3_cross");
        wr(0, 32'h11, 32'h55667788, 4'hF);       expect_err("wr_word1_cross");
        rd(0, 32'h10);                            expect_rd("rd_after_cross", 32'hBEEF3344);

        // Misaligned reads are lane-0 justified and never error.
        wr(0, 32'h20, 32'hAABBCCDD, 4'hF);
        rd(0, 32'h22);                            expect_rd("rd_off2", 32'h0000AABB);
        rd(0, 32'h23);                            expect_rd("rd_off3", 32'h000000AA);
        rd(0, 32'h21);                            expect_rd("rd_off1", 32'h00AABBCC);

        // Access phase without setup is ignored (compare process expects all zero).
        addr_v[0] = 32'h10; wr_v[0] = 1'b0; psel_v[0] = 1'b1; pen_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        psel_v[0] = 1'b0; pen_v[0] = 1'b0;
        check("no_setup pready", 32'(bus0.APB_pready), 32'h0);

        // Range boundary: last word fine, one past the end errors and writes nothing.
        wr(0, 32'h0, 32'hCAFEF00D, 4'hF);
        wr(0, 32'hFC, 32'h12345678, 4'hF);       expect_ok("wr_last");
        wr(0, 32'h100, 32'h55555555, 4'hF);      expect_err("wr_oor");
        rd(0, 32'h100);                           expect_err("rd_oor");
        rd(0, 32'h0);                             expect_rd("rd_word0_kept", 32'hCAFEF00D);
        rd(0, 32'hFC);                            expect_rd("rd_last", 32'h12345678);

        // Three wait states, base 0x100.
        wr(1, 32'h104, 32'h0BADF00D, 4'hF);      expect_ok("ws3_wr");
        rd(1, 32'h104);                           expect_rd("ws3_rd", 32'h0BADF00D);
        xfer(1, 32'h104, 1'b1, 32'hFFFFFFFF, 4'hF, 2, -1);
        check("abort pready", 32'(g_rdy), 32'h0);
        rd(1, 32'h104);                           expect_rd("rd_after_abort", 32'h0BADF00D);
        rd(1, 32'hFC);                            expect_err("rd_below_base");
        rd(1, 32'h200);                           expect_err("ws3_rd_oor");

        // Reset mid-wait, and reset in the completing cycle.
        xfer(1, 32'h104, 1'b1, 32'h11111111, 4'hF, -1, 2);
        check("rst_wait pready", 32'(g_rdy), 32'h0);
        xfer(1, 32'h104, 1'b1, 32'h22222222, 4'hF, -1, 4);
        check("rst_done saw pready", 32'(g_rdy), 32'h1);
        check("rst_done pready", 32'(bus1.APB_pready), 32'h0);
        check("rst_done perr", 32'(bus1.APB_perr), 32'h0);
        check("rst_done prdata", bus1.APB_prdata, 32'h0);
        rd(1, 32'h104);                           expect_rd("rd_after_rst", 32'h0BADF00D);

        // Back-to-back write then read of a fresh word.
        wr(1, 32'h108, 32'h600DCAFE, 4'hF);
        rd(1, 32'h109);                           expect_rd("b2b_rd", 32'h00600DCA);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
